// File: rtl/cby_io_pkg.sv
// Shared types and constants for the vertical connection-block I/O tile.
package cby_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } cfg_state_e;

  localparam logic MODE_IN  = 1'b1;
  localparam logic MODE_OUT = 1'b0;

  function automatic int sel_width(input int chan_w);
    return $clog2(2 * chan_w);
  endfunction

endpackage

// File: rtl/cby_io_pad_mux.sv
// One pad: picks a track from either channel direction and applies mode/isolation gating.
module cby_io_pad_mux
  import cby_io_pkg::*;
#(
  parameter int CHAN_W = 30,
  parameter int SEL_W  = 6
) (
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              isol_n,
  input  logic              soc_in,
  output logic              soc_out,
  output logic              soc_dir,
  output logic              inpad
);

  logic mux;

  // Compare-per-track keeps every index in range; codes >= 2*CHAN_W match nothing and yield 0.
  always_comb begin
    mux = 1'b0;
    for (int i = 0; i < CHAN_W; i++) begin
      if (sel == SEL_W'(i))          mux = chany_bottom_in[i];
      if (sel == SEL_W'(i + CHAN_W)) mux = chany_top_in[i];
    end
  end

  assign soc_out = isol_n & (mode == MODE_OUT) & mux;
  assign soc_dir = (mode == MODE_IN) | ~isol_n;
  assign inpad   = isol_n & (mode == MODE_IN) & soc_in;

endmodule

// File: rtl/cby_io_param.sv
// Vertical connection block with I/O pads: shadow config chain, guarded commit, per-pad muxing.
module cby_io_param
  import cby_io_pkg::*;
#(
  parameter int CHAN_W   = 30,
  parameter int NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                cfg_commit,
  input  logic                isol_n,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  input  logic [NUM_PADS-1:0] gfpga_pad_io_soc_in,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_dir,
  output logic [NUM_PADS-1:0] pin_inpad,
  output logic                ccff_tail,
  output logic                cfg_full,
  output logic                commit_err
);

  localparam int SEL_W    = sel_width(CHAN_W);
  localparam int PAD_BITS = SEL_W + 1;
  localparam int CFG_BITS = NUM_PADS * PAD_BITS;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);
  localparam logic [CFG_BITS-1:0] ACTIVE_RST = {NUM_PADS{{MODE_IN, {SEL_W{1'b0}}}}};

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  cfg_state_e          state_q, state_d;
  logic                commit_err_q, commit_err_d;
  logic                commit_ok;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_q     <= '0;
      active_q     <= ACTIVE_RST;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
      commit_err_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      commit_err_q <= commit_err_d;
    end
  end

  // Commit captures the pre-shift shadow; a same-cycle shift counts as the first bit of the next load.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    commit_ok    = cfg_commit && (state_q == ST_FULL);
    commit_err_d = cfg_commit && !commit_ok;
    if (ccff_shift_en) shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
    if (commit_ok) begin
      active_d = shadow_q;
      cnt_d    = ccff_shift_en ? CNT_W'(1) : '0;
    end else if (ccff_shift_en && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == '0)          state_d = ST_IDLE;
    else if (cnt_d == CNT_MAX) state_d = ST_FULL;
    else                      state_d = ST_LOADING;
  end

  assign ccff_tail  = shadow_q[CFG_BITS-1];
  assign cfg_full   = (state_q == ST_FULL);
  assign commit_err = commit_err_q;

  logic [NUM_PADS-1:0][PAD_BITS-1:0] pad_cfg;
  assign pad_cfg = active_q;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    cby_io_pad_mux #(
      .CHAN_W (CHAN_W),
      .SEL_W  (SEL_W)
    ) u_pad (
      .chany_bottom_in (chany_bottom_in),
      .chany_top_in    (chany_top_in),
      .sel             (pad_cfg[p][SEL_W-1:0]),
      .mode            (pad_cfg[p][SEL_W]),
      .isol_n          (isol_n),
      .soc_in          (gfpga_pad_io_soc_in[p]),
      .soc_out         (gfpga_pad_io_soc_out[p]),
      .soc_dir         (gfpga_pad_io_soc_dir[p]),
      .inpad           (pin_inpad[p])
    );
  end

endmodule

// File: tb/tb_cby_io_param.sv
// Directed bench for cby_io_param at default parameters (CHAN_W=30, NUM_PADS=4, 28 config bits).
module tb_cby_io_param;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic        ccff_head = 1'b0;
  logic        ccff_shift_en = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        isol_n = 1'b1;
  logic [29:0] chany_bottom_in = '0;
  logic [29:0] chany_top_in = '0;
  logic [3:0]  soc_in = '0;
  logic [29:0] chany_top_out, chany_bottom_out;
  logic [3:0]  soc_out, soc_dir, pin_inpad;
  logic        ccff_tail, cfg_full, commit_err;

  int total = 0;
  int bad = 0;

  cby_io_param dut (
    .prog_clk             (prog_clk),
    .prog_reset           (prog_reset),
    .ccff_head            (ccff_head),
    .ccff_shift_en        (ccff_shift_en),
    .cfg_commit           (cfg_commit),
    .isol_n               (isol_n),
    .chany_bottom_in      (chany_bottom_in),
    .chany_top_in         (chany_top_in),
    .gfpga_pad_io_soc_in  (soc_in),
    .chany_top_out        (chany_top_out),
    .chany_bottom_out     (chany_bottom_out),
    .gfpga_pad_io_soc_out (soc_out),
    .gfpga_pad_io_soc_dir (soc_dir),
    .pin_inpad            (pin_inpad),
    .ccff_tail            (ccff_tail),
    .cfg_full             (cfg_full),
    .commit_err           (commit_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset();
    prog_reset = 1'b1;
    tick();
    tick();
    prog_reset = 1'b0;
  endtask

  // MSB first, so bit i of w ends up in shadow bit i after 28 shifts.
  task automatic load(input logic [27:0] w);
    for (int i = 27; i >= 0; i--) begin
      ccff_head = w[i];
      ccff_shift_en = 1'b1;
      tick();
    end
    ccff_shift_en = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic shift_n(input int n);
    ccff_shift_en = 1'b1;
    for (int i = 0; i < n; i++) tick();
    ccff_shift_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  localparam logic [27:0] W_SEL5  = {7'h40, 7'h40, 7'h40, 7'h05};
  localparam logic [27:0] W_SEL35 = {7'h40, 7'h40, 7'h40, 7'h23};
  localparam logic [27:0] W_SEL62 = {7'h40, 7'h40, 7'h40, 7'h3E};
  localparam logic [27:0] PAT     = 28'hA5C396E;

  initial begin
    logic [27:0] got;

    // reset state
    do_reset();
    chk("rst_dir", soc_dir, 4'hF);
    chk("rst_out", soc_out, 4'h0);
    chk("rst_inpad", pin_inpad, 4'h0);
    chk("rst_full", cfg_full, 1'b0);
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_err", commit_err, 1'b0);

    // channel pass-through
    chany_bottom_in = 30'h2AAA_5555;
    chany_top_in    = 30'h1234_5678;
    #1;
    chk("pass_top", chany_top_out, 30'h2AAA_5555);
    chk("pass_bot", chany_bottom_out, 30'h1234_5678);

    // pad0 outpad on bottom track 5
    chany_bottom_in = 30'h0000_0020;
    chany_top_in    = '0;
    load(W_SEL5);
    chk("sel5_full", cfg_full, 1'b1);
    chk("sel5_precommit_out", soc_out, 4'h0);
    commit();
    chk("sel5_out", soc_out, 4'h1);
    chk("sel5_dir", soc_dir, 4'hE);
    chk("sel5_full_clr", cfg_full, 1'b0);
    chk("sel5_err", commit_err, 1'b0);

    // sel 35 -> top track 5; shifting must not disturb the live config
    load(W_SEL35);
    chk("sel35_shift_hold", soc_out, 4'h1);
    commit();
    chk("sel35_bot_only", soc_out, 4'h0);
    chany_bottom_in = '0;
    chany_top_in    = 30'h0000_0020;
    #1;
    chk("sel35_top", soc_out, 4'h1);

    // sel 62 is beyond both channels
    chany_bottom_in = '1;
    chany_top_in    = '1;
    load(W_SEL62);
    commit();
    chk("sel62_out", soc_out, 4'h0);
    chk("sel62_dir", soc_dir, 4'hE);

    // commit after 10 shifts is rejected
    do_reset();
    shift_n(10);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("early_err", commit_err, 1'b1);
    chk("early_dir", soc_dir, 4'hF);
    tick();
    chk("early_err_pulse", commit_err, 1'b0);
    shift_n(17);
    chk("early_cnt27", cfg_full, 1'b0);
    shift_n(1);
    chk("early_cnt28", cfg_full, 1'b1);

    // commit with concurrent shift: pre-shift data goes live, count restarts at 1
    do_reset();
    chany_bottom_in = 30'h0000_0020;
    chany_top_in    = '0;
    load(W_SEL5);
    cfg_commit = 1'b1;
    ccff_shift_en = 1'b1;
    ccff_head = 1'b1;
    tick();
    cfg_commit = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head = 1'b0;
    chk("cs_out", soc_out, 4'h1);
    chk("cs_full", cfg_full, 1'b0);
    shift_n(26);
    chk("cs_cnt27", cfg_full, 1'b0);
    shift_n(1);
    chk("cs_cnt28", cfg_full, 1'b1);

    // inpad path and isolation
    soc_in = 4'b0100;
    isol_n = 1'b1;
    #1;
    chk("inpad_on", pin_inpad, 4'b0100);
    isol_n = 1'b0;
    #1;
    chk("isol_inpad", pin_inpad, 4'h0);
    chk("isol_out", soc_out, 4'h0);
    chk("isol_dir", soc_dir, 4'hF);
    isol_n = 1'b1;
    soc_in = '0;

    // chain latency: the pattern comes out of the tail in order
    do_reset();
    load(PAT);
    got = '0;
    for (int i = 0; i < 28; i++) begin
      got = {got[26:0], ccff_tail};
      shift_n(1);
    end
    chk("chain_pat", got, PAT);
    chk("chain_full", cfg_full, 1'b1);
    chk("chain_dir", soc_dir, 4'hF);
    chk("chain_out", soc_out, 4'h0);

    // reset mid-load dominates shift and commit
    do_reset();
    load(28'hFFFFFFF);
    do_reset();
    ccff_head = 1'b1;
    shift_n(15);
    prog_reset = 1'b1;
    ccff_shift_en = 1'b1;
    cfg_commit = 1'b1;
    tick();
    prog_reset = 1'b0;
    ccff_shift_en = 1'b0;
    cfg_commit = 1'b0;
    ccff_head = 1'b0;
    chk("mid_full", cfg_full, 1'b0);
    chk("mid_tail", ccff_tail, 1'b0);
    chk("mid_err", commit_err, 1'b0);
    chk("mid_dir", soc_dir, 4'hF);
    commit();
    chk("mid_commit_err", commit_err, 1'b1);
    shift_n(27);
    chk("mid_cnt27", cfg_full, 1'b0);
    chk("mid_tail_clr", ccff_tail, 1'b0);
    shift_n(1);
    chk("mid_cnt28", cfg_full, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cby_io_param.md
CBY_IO_PARAM -- requirements
Module: cby_io_param

Interface
REQ-001 Parameter CHAN_W, default 30, SHALL set the number of vertical channel tracks per direction.
REQ-002 Parameter NUM_PADS, default 4, SHALL set the number of I/O pads/subtiles.
REQ-003 Derived SEL_W = clog2(2*CHAN_W) (6 at defaults), PAD_BITS = SEL_W+1, CFG_BITS = NUM_PADS*PAD_BITS (28 at defaults).
REQ-004 prog_clk  in  1  sole clock; all state rising-edge.
REQ-005 prog_reset  in  1  synchronous, active-high reset.
REQ-006 ccff_head  in  1  configuration chain serial input.
REQ-007 ccff_shift_en  in  1  shift one config bit per cycle when high.
REQ-008 cfg_commit  in  1  request copy of shadow config to active config.
REQ-009 isol_n  in  1  low = isolate all pads from fabric.
REQ-010 chany_bottom_in / chany_top_in  in  CHAN_W  channel tracks.
REQ-011 gfpga_pad_io_soc_in  in  NUM_PADS  pad input values.
REQ-012 chany_top_out / chany_bottom_out  out  CHAN_W  channel pass-through.
REQ-013 gfpga_pad_io_soc_out / gfpga_pad_io_soc_dir  out  NUM_PADS  pad drive value / direction (1 = input).
REQ-014 pin_inpad  out  NUM_PADS  pad values delivered to fabric.
REQ-015 ccff_tail  out  1  chain serial output; cfg_full  out  1; commit_err  out  1.

Function
REQ-016 chany_top_out SHALL equal chany_bottom_in and chany_bottom_out SHALL equal chany_top_in, combinationally.
REQ-017 Shadow register (CFG_BITS) on ccff_shift_en: shadow <= {shadow[CFG_BITS-2:0], ccff_head}; ccff_tail = shadow[CFG_BITS-1], so chain latency is CFG_BITS cycles of shift_en.
REQ-018 Active field for pad p = active[p*PAD_BITS +: PAD_BITS] = {mode, sel}; mode 1 = inpad, 0 = outpad.
REQ-019 Mux source for pad p: sel < CHAN_W -> chany_bottom_in[sel]; CHAN_W <= sel < 2*CHAN_W -> chany_top_in[sel-CHAN_W]; sel >= 2*CHAN_W -> 0.
REQ-020 soc_out[p] = isol_n & ~mode & mux; soc_dir[p] = mode | ~isol_n; pin_inpad[p] = isol_n & mode & soc_in[p]; all combinational from active config.
REQ-021 Shift counter SHALL increment per shift_en, saturating at CFG_BITS; extra shifts still move the shadow.
REQ-022 FSM states: IDLE (count 0), LOADING (0 < count < CFG_BITS), FULL (count = CFG_BITS); cfg_full = (state == FULL).
REQ-023 cfg_commit in FULL SHALL load active <= shadow next edge, then counter cleared to 0 (or 1 if shift_en same cycle; committed data is pre-shift shadow).
REQ-024 cfg_commit outside FULL SHALL leave active unchanged and pulse commit_err high for exactly one cycle; counter unaffected.
REQ-025 Active config SHALL change only on a valid commit; shifting SHALL never disturb soc_out/soc_dir/pin_inpad.

Reset
REQ-026 On prog_reset: shadow = 0, counter = 0, state IDLE, commit_err = 0, ccff_tail = 0.
REQ-027 On prog_reset active config SHALL become mode=1, sel=0 for every pad (soc_dir = all 1s, soc_out = 0).
REQ-028 Reset mid-load SHALL discard partial shadow; reset dominates commit and shift in the same cycle.

Structure
REQ-029 Package cby_io_pkg SHALL hold the state enum, mode encoding constants (MODE_IN, MODE_OUT), and a SEL_W width function.
REQ-030 Per-pad logic (REQ-019/020) SHALL be sub-module cby_io_pad_mux, instantiated NUM_PADS times.

Verification
REQ-031 Reset, defaults -> soc_dir=4'hF, soc_out=0, pin_inpad=0, cfg_full=0, ccff_tail=0.
REQ-032 Shift 28 bits setting pad0 {0,sel=5}, commit, bottom_in[5]=1 -> soc_out[0]=1, soc_dir[0]=0; sel=35 routes top_in[5]; sel=62 -> soc_out[0]=0.
REQ-033 cfg_commit after 10 shifts -> commit_err one-cycle pulse, outputs unchanged, count stays 10.
REQ-034 Pad2 mode=1, soc_in[2]=1, isol_n=1 -> pin_inpad[2]=1; drop isol_n -> pin_inpad=0, soc_out=0, soc_dir=4'hF.
REQ-035 Shift known 28-bit pattern, continue 28 more shifts -> ccff_tail reproduces pattern in order; cfg_full stays 1, active unchanged without commit.
REQ-036 prog_reset asserted at shift 15 -> count 0, state IDLE, subsequent commit gives commit_err.
